// File: rtl/csr_access_unit.sv
// csr_access_unit: executes Zicsr read-modify-write accesses over the CSR bus
module csr_access_unit #(
  parameter int RD_TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_VALID,
  output logic        INST_READY,
  input  logic [2:0]  INST_FUNCT3,
  input  logic [11:0] INST_CSR,
  input  logic [4:0]  INST_RS1,
  input  logic [31:0] INST_RS1_DATA,
  input  logic [4:0]  INST_RD,
  input  logic        FLUSH,
  output logic        RDEN,
  output logic [11:0] RADDR,
  input  logic        RVALID,
  input  logic [31:0] RDATA,
  output logic        WREN,
  output logic [11:0] WADDR,
  output logic [31:0] WDATA,
  output logic        RESULT_VALID,
  output logic [4:0]  RESULT_RD,
  output logic [31:0] RESULT_DATA,
  output logic        EXC_ILLEGAL
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);
  state_t st, nx;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [4:0]  rd;
  logic [31:0] opnd, old;
  logic [3:0]  cnt;
  logic        dw, ill;
  logic        accept, dr_in, dw_in, ill_in;
  assign accept = INST_VALID && INST_READY && !FLUSH;
  assign dr_in  = !(INST_FUNCT3[1:0] == 2'b01 && INST_RD == 5'd0);
  assign dw_in  = !(INST_FUNCT3[1] && INST_RS1 == 5'd0);
  assign ill_in = INST_FUNCT3[1:0] == 2'b00 || (dw_in && INST_CSR[11:10] == 2'b11);
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) st <= IDLE;
    else st <= nx;
  // next-state logic; flush abandons any access not yet written
  always_comb begin
    nx = st;
    case (st)
      IDLE:  nx = !accept ? IDLE : ill_in ? DONE : dr_in ? READ : WRITE;
      READ:  nx = FLUSH ? IDLE : RVALID ? (dw ? WRITE : DONE) : (cnt == TO_LAST ? DONE : READ);
      WRITE: nx = FLUSH ? IDLE : DONE;
      DONE:  nx = IDLE;
    endcase
  end
  // instruction latch, read capture and timeout counter
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      op   <= '0;
      addr <= '0;
      rd   <= '0;
      opnd <= '0;
      old  <= '0;
      cnt  <= '0;
      dw   <= 1'b0;
      ill  <= 1'b0;
    end else if (accept) begin
      op   <= INST_FUNCT3[1:0];
      addr <= INST_CSR;
      rd   <= INST_RD;
      opnd <= INST_FUNCT3[2] ? {27'd0, INST_RS1} : INST_RS1_DATA;
      old  <= '0;
      cnt  <= '0;
      dw   <= dw_in;
      ill  <= ill_in;
    end else if (st == READ) begin
      if (RVALID) old <= RDATA;
      else begin
        cnt <= cnt + 4'd1;
        if (cnt == TO_LAST) ill <= 1'b1;
      end
    end
  // bus strobes and result; data buses are zero whenever their strobe is low
  always_comb begin
    INST_READY   = st == IDLE && !RST;
    RDEN         = st == READ;
    RADDR        = RDEN ? addr : 12'd0;
    WREN         = st == WRITE;
    WADDR        = WREN ? addr : 12'd0;
    WDATA        = !WREN ? 32'd0 : op == 2'b01 ? opnd : op == 2'b10 ? (old | opnd) : (old & ~opnd);
    RESULT_VALID = st == DONE && !FLUSH;
    RESULT_RD    = RESULT_VALID && !ill ? rd : 5'd0;
    RESULT_DATA  = RESULT_VALID ? old : 32'd0;
    EXC_ILLEGAL  = RESULT_VALID && ill;
  end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR access bus: executes Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) on behalf of the execute stage.
- Issues a read on RDEN/RADDR and waits for RVALID/RDATA from the CSR register file.
- Computes the new value, issues a single-cycle write on WREN/WADDR/WDATA, and returns the old CSR value for rd writeback.
- Flags illegal accesses: unimplemented CSR (read timeout) and write to a read-only CSR.

Parameters:
- RD_TIMEOUT, 4, maximum cycles RDEN is held in READ without RVALID before the access is declared unimplemented (legal range 1..15).

Ports:
- CLK  input  1  clock
- RST  input  1  reset (all state and registered outputs)
- INST_VALID  input  1  Zicsr instruction presented
- INST_READY  output  1  unit can accept; high only in IDLE
- INST_FUNCT3  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal
- INST_CSR  input  12  CSR address
- INST_RS1  input  5  rs1 index, or zimm for immediate forms
- INST_RS1_DATA  input  32  rs1 register value
- INST_RD  input  5  destination register index
- FLUSH  input  1  pipeline flush; aborts any uncommitted access
- RDEN  output  1  CSR read request
- RADDR  output  12  CSR read address
- RVALID  input  1  read response valid (may arrive in the same cycle as RDEN)
- RDATA  input  32  read data, qualified by RVALID
- WREN  output  1  CSR write strobe
- WADDR  output  12  CSR write address
- WDATA  output  32  CSR write data
- RESULT_VALID  output  1  one-cycle completion pulse
- RESULT_RD  output  5  writeback register index (0 means no writeback)
- RESULT_DATA  output  32  old CSR value (0 if the read was skipped)
- EXC_ILLEGAL  output  1  qualified by RESULT_VALID; illegal-instruction exception

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. While RST is high all registered outputs are 0 and the FSM is in IDLE. INST_READY is 1 after reset.
- Accept: an instruction is accepted when INST_VALID and INST_READY are both high in IDLE. On accept, latch funct3, addr, rd, and the operand.
  - Operand = INST_RS1_DATA for register forms.
  - Operand = zero-extended INST_RS1 for immediate forms.
- Decode at accept:
  - do_read = 0 only for RW/RWI with rd=0; 1 otherwise.
  - do_write = 0 for RS/RC/RSI/RCI with INST_RS1=0; 1 otherwise.
  - Illegal if funct3 is 000 or 100.
  - Illegal if do_write=1 and addr[11:10]=11 (read-only CSR).
  - An illegal instruction goes straight to DONE with EXC_ILLEGAL=1 and issues no RDEN and no WREN.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE to READ when do_read=1; IDLE to WRITE when do_read=0.
  - READ: RDEN=1 and RADDR=addr, held every cycle in READ.
    - If RVALID=1, capture RDATA as old and go to WRITE (do_write=1) or DONE.
    - Otherwise increment the wait counter. When the counter reaches RD_TIMEOUT with no RVALID, go to DONE with EXC_ILLEGAL=1 and no write.
  - WRITE: one cycle with WREN=1 and WADDR=addr. WDATA is:
    - RW: operand
    - RS: old OR operand
    - RC: old AND NOT operand
    - Then go to DONE.
  - DONE: one cycle with RESULT_VALID=1.
    - RESULT_RD = rd, forced to 0 when EXC_ILLEGAL=1.
    - RESULT_DATA = old.
    - Then go to IDLE.
- Latency: from the accept cycle N, with RVALID arriving in the RDEN cycle:
  - Read+write: RDEN at N+1, WREN at N+2, RESULT_VALID at N+3.
  - Write-only: WREN at N+1, RESULT_VALID at N+2.
  - Each RVALID wait cycle adds one cycle.
- Output defaults: RDEN, WREN, and RESULT_VALID are 0 outside their states. RADDR, WADDR, and WDATA are 0 when their strobe is low.
- FLUSH:
  - In READ or DONE: return to IDLE next cycle, no WREN, no RESULT_VALID.
  - In WRITE: the write is already committed and still occurs; DONE is suppressed.
  - In IDLE: blocks accept in that cycle.
- Ignored inputs: RVALID outside READ is ignored. INST_VALID while not in IDLE is ignored (INST_READY=0).
- Reset mid-operation: the FSM returns to IDLE immediately, with no partial WREN after reset deasserts.

Test Plan:
- CSRRS, addr 0x300, rs1_data 0x8, rd=5; CSR file returns 0x1800 with RVALID coincident with RDEN -> RDEN at N+1, WREN at N+2 with WDATA 0x1808, RESULT_VALID at N+3 with RD=5, DATA 0x1800, EXC_ILLEGAL=0.
- CSRRWI, addr 0x340, zimm 0x1F, rd=0 -> no RDEN; WREN at N+1 with WDATA 0x0000001F; RESULT_VALID at N+2 with RD=0.
- CSRRC, addr 0x304, rs1=x0, rd=3; RVALID delayed 2 cycles, RDATA 0xFFFF0000 -> RDEN held 3 cycles, no WREN, RESULT_DATA 0xFFFF0000.
- CSRRS, addr 0x7C0, RVALID never asserted, RD_TIMEOUT=4 -> RDEN high for exactly 4 cycles, then RESULT_VALID with EXC_ILLEGAL=1, RD=0, no WREN.
- CSRRW to 0xC00 (read-only) -> no RDEN or WREN, RESULT_VALID at N+1 with EXC_ILLEGAL=1. CSRRS to 0xC00 with rs1=x0 -> legal read, no illegal flag.
- FLUSH during READ, then RST asserted mid-READ on a separate run -> both cases: no WREN, no RESULT_VALID, INST_READY=1 next cycle; under reset all outputs read 0 asynchronously.
